vedic_4bit_seq: RTL and testbench

- Multi-cycle 4x4 unsigned Vedic multiplier, sitting directly downstream of the 2x2 Vedic cell and consuming its 4-bit products.
- A single 2x2 cell is time-multiplexed over four cycles, one 2-bit operand chunk pair per cycle.
- Each 4-bit partial product is shifted and added into an 8-bit accumulator.
- Valid/ready handshakes on both sides let the block sit in a streaming datapath between a stimulus source and a result consumer.

---
 rtl/vedic_pkg.sv | 23 ++
 rtl/vedic_4bit_seq_if.sv | 23 ++
 rtl/vedic_2bit.sv | 23 ++
 rtl/vedic_4bit_seq.sv | 135 +++++++++++++
 tb/tb_vedic_4bit_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/vedic_pkg.sv
// Shared types and constants for the sequential 4x4 Vedic multiplier.
package vedic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PP0,
    PP1,
    PP2,
    PP3,
    DONE
  } vedic_seq_state_t;

  localparam int OP_W    = 4;
  localparam int CHUNK_W = 2;
  localparam int PROD_W  = 8;

  // Left shift applied to each 4-bit partial product before accumulation.
  localparam int SH_PP0 = 0;
  localparam int SH_PP1 = 2;
  localparam int SH_PP2 = 2;
  localparam int SH_PP3 = 4;

endpackage

// File: rtl/vedic_4bit_seq_if.sv
// Operand/result valid-ready bundle for vedic_4bit_seq.
interface vedic_4bit_seq_if;
  import vedic_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );

endinterface

// File: rtl/vedic_2bit.sv
// 2x2 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier cell, purely combinational.
module vedic_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic cross_lo;
  logic cross_hi;
  logic vert_hi;
  logic carry1;

  assign cross_lo = a[1] & b[0];
  assign cross_hi = a[0] & b[1];
  assign vert_hi  = a[1] & b[1];
  assign carry1   = cross_lo & cross_hi;

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_lo ^ cross_hi;
  assign p[2] = vert_hi ^ carry1;
  assign p[3] = vert_hi & carry1;

endmodule

// File: rtl/vedic_4bit_seq.sv
// Multi-cycle 4x4 Vedic multiplier reusing one 2x2 cell over four partial-product cycles.
// Optional build macro VEDIC_SEQ_ZERO_SKIP_EN: zero operands jump straight to DONE.
module vedic_4bit_seq
  import vedic_pkg::*;
#(
  parameter bit OUT_HOLD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  vedic_4bit_seq_if.slave   io,
  output logic              busy
);

  vedic_seq_state_t  state_q, state_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [OP_W-1:0]   op_a_q, op_a_d;
  logic [OP_W-1:0]   op_b_q, op_b_d;
  logic [PROD_W-1:0] out_p_q, out_p_d;
  logic              out_valid_q, out_valid_d;

  logic [CHUNK_W-1:0]   chunk_a;
  logic [CHUNK_W-1:0]   chunk_b;
  logic [2:0]           shamt;
  logic [2*CHUNK_W-1:0] pp;
  logic [PROD_W-1:0]    pp_ext;
  logic [PROD_W-1:0]    acc_sum;

  // Chunk pair and weight for the current partial-product step.
  always_comb begin
    chunk_a = op_a_q[CHUNK_W-1:0];
    chunk_b = op_b_q[CHUNK_W-1:0];
    shamt   = 3'(SH_PP0);
    case (state_q)
      PP1: begin
        chunk_a = op_a_q[OP_W-1:CHUNK_W];
        shamt   = 3'(SH_PP1);
      end
      PP2: begin
        chunk_b = op_b_q[OP_W-1:CHUNK_W];
        shamt   = 3'(SH_PP2);
      end
      PP3: begin
        chunk_a = op_a_q[OP_W-1:CHUNK_W];
        chunk_b = op_b_q[OP_W-1:CHUNK_W];
        shamt   = 3'(SH_PP3);
      end
      default: ;
    endcase
  end

  vedic_2bit u_cell (
    .a (chunk_a),
    .b (chunk_b),
    .p (pp)
  );

  assign pp_ext  = PROD_W'(pp) << shamt;
  assign acc_sum = acc_q + pp_ext;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          op_a_d  = io.in_a;
          op_b_d  = io.in_b;
          acc_d   = '0;
          state_d = PP0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
          if ((io.in_a == '0) || (io.in_b == '0)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_p_d     = '0;
          end
`endif
        end
      end
      PP0: begin
        acc_d   = acc_sum;
        state_d = PP1;
      end
      PP1: begin
        acc_d   = acc_sum;
        state_d = PP2;
      end
      PP2: begin
        acc_d   = acc_sum;
        state_d = PP3;
      end
      PP3: begin
        acc_d       = acc_sum;
        state_d     = DONE;
        out_valid_d = 1'b1;
        out_p_d     = acc_sum;
      end
      DONE: begin
        if (io.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          if (!OUT_HOLD) out_p_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.out_p     = out_p_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_vedic_4bit_seq.sv
// Scoreboard bench for vedic_4bit_seq: two instances (OUT_HOLD=1 and OUT_HOLD=0) share stimulus.
module tb_vedic_4bit_seq;
  import vedic_pkg::*;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 5;
`endif
  localparam int LAT_FULL = 5;

  typedef struct {
    logic [7:0] p;
    int         acc_cyc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy_h, busy_c;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  bit   thru_on = 1'b0;

  vedic_4bit_seq_if io_h ();
  vedic_4bit_seq_if io_c ();

  assign io_c.in_valid  = io_h.in_valid;
  assign io_c.in_a      = io_h.in_a;
  assign io_c.in_b      = io_h.in_b;
  assign io_c.out_ready = io_h.out_ready;

  vedic_4bit_seq #(.OUT_HOLD(1'b1)) dut_hold (
    .clk  (clk),
    .rst  (rst),
    .io   (io_h),
    .busy (busy_h)
  );

  vedic_4bit_seq #(.OUT_HOLD(1'b0)) dut_clr (
    .clk  (clk),
    .rst  (rst),
    .io   (io_c),
    .busy (busy_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, product on each handshake.
  logic prev_v = 1'b0;
  int   thru_prev = -1;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      chk("in_ready_vs_busy", int'(io_h.in_ready), int'(!busy_h));
      if (io_h.out_valid && !prev_v) begin
        chk("sb_depth_at_valid", sb.size(), 1);
        if (sb.size() > 0) chk("latency", cyc - sb[0].acc_cyc, sb[0].lat);
      end
      if (io_h.out_valid && io_h.out_ready) begin
        chk("sb_depth_at_handshake", sb.size(), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("out_p_hold", int'(io_h.out_p), int'(mon_e.p));
          chk("out_p_clr", int'(io_c.out_p), int'(mon_e.p));
        end
        if (thru_on) begin
          if (thru_prev >= 0) chk("throughput", cyc - thru_prev, 6);
          thru_prev = cyc;
        end
      end
      if (!thru_on) thru_prev = -1;
      prev_v = io_h.out_valid;
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] p, input int lat);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!io_h.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io_h.in_ready) begin
      chk("accept_timeout", int'(io_h.in_ready), 1);
    end else begin
      io_h.in_valid = 1'b1;
      io_h.in_a     = a;
      io_h.in_b     = b;
      e.p       = p;
      e.acc_cyc = cyc;
      e.lat     = lat;
      sb.push_back(e);
      @(posedge clk);
      #1;
      io_h.in_valid = 1'b0;
      io_h.in_a     = ~a;
      io_h.in_b     = ~b;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic check_idle(input string tag, input int p_hold, input int p_clr);
    chk({tag, "_in_ready"}, int'(io_h.in_ready), 1);
    chk({tag, "_busy"}, int'(busy_h), 0);
    chk({tag, "_busy_clr"}, int'(busy_c), 0);
    chk({tag, "_out_valid"}, int'(io_h.out_valid), 0);
    chk({tag, "_out_p_hold"}, int'(io_h.out_p), p_hold);
    chk({tag, "_out_p_clr"}, int'(io_c.out_p), p_clr);
  endtask

  initial begin
    int n;
    rst            = 1'b1;
    io_h.in_valid  = 1'b0;
    io_h.in_a      = 4'd0;
    io_h.in_b      = 4'd0;
    io_h.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset", 0, 0);

    // 15*15 with consumer always ready
    send(4'd15, 4'd15, 8'hE1, LAT_FULL);
    drain();

    // 9*6 with consumer stalled; a competing request is ignored
    @(posedge clk);
    #1 io_h.out_ready = 1'b0;
    send(4'd9, 4'd6, 8'd54, LAT_FULL);
    n = 0;
    while (!io_h.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_done", int'(io_h.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        io_h.in_valid = 1'b1;
        io_h.in_a     = 4'd3;
        io_h.in_b     = 4'd3;
      end
      if (i == 7) io_h.in_valid = 1'b0;
      @(negedge clk);
      chk("stall_valid", int'(io_h.out_valid), 1);
      chk("stall_p", int'(io_h.out_p), 54);
      chk("stall_busy", int'(busy_h), 1);
    end
    @(posedge clk);
    #1 io_h.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("stall_release", 54, 0);
    chk("stall_sb_empty", sb.size(), 0);

    // exhaustive back-to-back
`ifndef VEDIC_SEQ_ZERO_SKIP_EN
    thru_on = 1'b1;
`endif
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(4'(a), 4'(b), 8'(a * b), (a == 0 || b == 0) ? LAT_ZERO : LAT_FULL);
      end
    end
    drain();
    thru_on = 1'b0;

    // reset during PP2 of 7*11
    send(4'd7, 4'd11, 8'd77, LAT_FULL);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("mid_reset", 0, 0);
    send(4'd3, 4'd5, 8'd15, LAT_FULL);
    drain();

    // zero operand
    send(4'd0, 4'd13, 8'd0, LAT_ZERO);
    drain();

    // output hold vs clear after handshake
    send(4'd12, 4'd12, 8'd144, LAT_FULL);
    drain();
    @(posedge clk);
    @(negedge clk);
    check_idle("out_hold", 144, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
